// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared types and cipher round arithmetic for crypt_engine
// Functions work on a WMAX-bit word masked to the active width n, so one package serves any N <= WMAX.
package crypt_pkg;

  localparam int WMAX = 32;

  typedef logic [WMAX-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic word_t width_mask(input int n);
    word_t m;
    m = '0;
    for (int i = 0; i < WMAX; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic word_t rotl(input word_t x, input int s, input int n);
    word_t xm;
    int    sh;
    xm = x & width_mask(n);
    sh = s % n;
    if (sh == 0) return xm;
    return ((xm << sh) | (xm >> (n - sh))) & width_mask(n);
  endfunction

  function automatic word_t rotr(input word_t x, input int s, input int n);
    word_t xm;
    int    sh;
    xm = x & width_mask(n);
    sh = s % n;
    if (sh == 0) return xm;
    return ((xm >> sh) | (xm << (n - sh))) & width_mask(n);
  endfunction

  function automatic word_t round_key(input word_t key, input int r, input int n);
    return rotl(key, r % n, n) ^ (word_t'(r) & width_mask(n));
  endfunction

  function automatic word_t enc_round(input word_t x, input word_t k, input int n);
    return (rotl(x ^ k, 1, n) + k) & width_mask(n);
  endfunction

  // Undoes enc_round step by step in reverse: subtract, rotate back, unmask.
  function automatic word_t dec_round(input word_t x, input word_t k, input int n);
    return (rotr((x - k) & width_mask(n), 1, n) ^ k) & width_mask(n);
  endfunction

endpackage

// File: rtl/crypt_round_unit.sv
// rtl/crypt_round_unit.sv - one combinational cipher round, direction chosen by mode
// The round key is derived from the live round index so the engine only sequences the counter.
module crypt_round_unit
  import crypt_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] key,
  input  logic [N-1:0] rnd,
  input  logic         mode,
  output logic [N-1:0] y
);

  word_t k;

  always_comb begin
    k = round_key(word_t'(key), int'(rnd), N);
    if (mode) begin
      y = N'(dec_round(word_t'(x), k, N));
    end else begin
      y = N'(enc_round(word_t'(x), k, N));
    end
  end

endmodule

// File: rtl/crypt_engine.sv
// rtl/crypt_engine.sv - iterative encrypt/decrypt engine with valid/ready handshakes and running MAC
// One round per clock; x_q is the working register, out_data_q only changes on entry into DONE.
module crypt_engine
  import crypt_pkg::*;
#(
  parameter int N      = 8,
  parameter int ROUNDS = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [N-1:0] key,
  input  logic [N-1:0] data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [N-1:0] mac,
  input  logic         mac_clear
);

  localparam logic [N-1:0] LAST = N'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [N-1:0] x_q, x_d;
  logic [N-1:0] key_q, key_d;
  logic         mode_q, mode_d;
  logic [N-1:0] din_q, din_d;
  logic [N-1:0] rnd_q, rnd_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic [N-1:0] mac_q, mac_d;
  logic [N-1:0] round_y;

  crypt_round_unit #(.N(N)) u_round (
    .x    (x_q),
    .key  (key_q),
    .rnd  (rnd_q),
    .mode (mode_q),
    .y    (round_y)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    key_d      = key_q;
    mode_d     = mode_q;
    din_d      = din_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
    mac_d      = mac_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          key_d   = key;
          mode_d  = mode;
          x_d     = data;
          din_d   = data;
          rnd_d   = mode ? LAST : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = round_y;
        if (rnd_q == (mode_q ? '0 : LAST)) begin
          state_d    = DONE;
          rnd_d      = '0;
          out_data_d = round_y;
          // The MAC always covers ciphertext: the result when encrypting, the input when decrypting.
          mac_d      = {mac_q[N-2:0], mac_q[N-1]} ^ (mode_q ? din_q : round_y);
        end else begin
          rnd_d = mode_q ? (rnd_q - N'(1)) : (rnd_q + N'(1));
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (mac_clear) mac_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      din_q      <= '0;
      rnd_q      <= '0;
      out_data_q <= '0;
      mac_q      <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      din_q      <= din_d;
      rnd_q      <= rnd_d;
      out_data_q <= out_data_d;
      mac_q      <= mac_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign mac       = mac_q;

endmodule

// File: tb/tb_crypt_engine.sv
// tb/tb_crypt_engine.sv - scoreboard bench for crypt_engine (N=8, ROUNDS=4)
module tb_crypt_engine;
  import crypt_pkg::*;

  localparam int N      = 8;
  localparam int ROUNDS = 4;

  logic         clock     = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic         mode      = 1'b0;
  logic [N-1:0] key       = '0;
  logic [N-1:0] data      = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic [N-1:0] mac;
  logic         mac_clear = 1'b0;

  typedef struct {
    logic [N-1:0] d;
    logic [N-1:0] m;
  } exp_t;

  exp_t         sb[$];
  logic [N-1:0] model_mac = '0;
  int           checks = 0;
  int           errors = 0;

  crypt_engine #(.N(N), .ROUNDS(ROUNDS)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .key       (key),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mac       (mac),
    .mac_clear (mac_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_block(input logic m, input logic [N-1:0] k,
                                               input logic [N-1:0] d);
    word_t x;
    x = word_t'(d);
    if (!m) begin
      for (int r = 0; r < ROUNDS; r++) x = enc_round(x, round_key(word_t'(k), r, N), N);
    end else begin
      for (int r = ROUNDS - 1; r >= 0; r--) x = dec_round(x, round_key(word_t'(k), r, N), N);
    end
    return N'(x);
  endfunction

  // Called #1 after a clock edge; drives one block through the accept edge and scores it.
  task automatic send(input logic m, input logic [N-1:0] k, input logic [N-1:0] d, input bit clr);
    exp_t         e;
    logic [N-1:0] c;
    check("accept_ready", 32'(in_ready), 32'd1);
    e.d       = model_block(m, k, d);
    c         = m ? d : e.d;
    model_mac = clr ? '0 : ({model_mac[N-2:0], model_mac[N-1]} ^ c);
    e.m       = model_mac;
    sb.push_back(e);
    mode     = m;
    key      = k;
    data     = d;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    mode     = 1'($urandom);
    key      = N'($urandom);
    data     = N'($urandom);
  endtask

  task automatic collect(input int hold, input bit clr);
    int           lat;
    bit           busy_ok;
    bit           stable_ok;
    exp_t         e;
    logic [N-1:0] held;
    lat       = 0;
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    while (!out_valid && lat < 50) begin
      if (clr && lat == ROUNDS - 1) mac_clear = 1'b1;
      if (in_ready) busy_ok = 1'b0;
      @(posedge clock);
      lat++;
      #1;
      mac_clear = 1'b0;
    end
    check("latency", 32'(lat), 32'(ROUNDS));
    check("in_ready_busy", 32'(busy_ok), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 32'd1);
      e.d = '0;
      e.m = '0;
    end else begin
      e = sb.pop_front();
    end
    check("out_data", 32'(out_data), 32'(e.d));
    check("mac", 32'(mac), 32'(e.m));
    held = out_data;
    repeat (hold) begin
      @(posedge clock);
      #1;
      if (!out_valid || out_data !== held || in_ready || mac !== e.m) stable_ok = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", 32'(stable_ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("data_hold", 32'(out_data), 32'(held));
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] k;
    logic [N-1:0] d;
    logic [N-1:0] c;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_mac", 32'(mac), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    send(1'b0, 8'h00, 8'h01, 1'b0);
    collect(0, 1'b0);
    check("tp1_data", 32'(out_data), 32'h21);
    check("tp1_mac", 32'(mac), 32'h21);

    send(1'b0, 8'h0F, 8'h02, 1'b0);
    collect(0, 1'b0);
    check("tp2_data", 32'(out_data), 32'h20);
    check("tp2_mac", 32'(mac), 32'h62);

    send(1'b1, 8'h00, 8'h21, 1'b0);
    collect(0, 1'b0);
    check("tp3_dec", 32'(out_data), 32'h01);
    check("tp3_mac", 32'(mac), 32'hE5);

    send(1'b0, 8'hA5, 8'h3C, 1'b0);
    collect(10, 1'b0);

    send(1'b0, 8'h12, 8'h34, 1'b1);
    collect(0, 1'b1);
    check("clr_mac", 32'(mac), 32'h00);
    send(1'b0, 8'h00, 8'h01, 1'b0);
    collect(0, 1'b0);
    check("after_clr_mac", 32'(mac), 32'h21);

    // Abort a block two rounds in; its scoreboard entry is discarded.
    send(1'b0, 8'h55, 8'h3C, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #2;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_mac", 32'(mac), 32'd0);
    #2;
    reset_n   = 1'b1;
    model_mac = '0;
    @(posedge clock);
    #1;
    check("post_abort_out_valid", 32'(out_valid), 32'd0);
    check("post_abort_mac", 32'(mac), 32'd0);
    send(1'b0, 8'h00, 8'h01, 1'b0);
    collect(0, 1'b0);
    check("post_abort_data", 32'(out_data), 32'h21);

    for (int i = 0; i < 256; i++) begin
      k = N'($urandom);
      d = N'($urandom);
      send(1'b0, k, d, 1'b0);
      collect(0, 1'b0);
      c = out_data;
      send(1'b1, k, c, 1'b0);
      collect(0, 1'b0);
      check("roundtrip", 32'(out_data), 32'(d));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
